// File: rtl/pc_ctrl_unit.sv
// rtl/pc_ctrl_unit.sv - fetch-stage program counter with redirect buffer, halt and exception vectoring
//
// Purpose:
//   Holds the instruction fetch address. After reset it spends one bubble
//   cycle in BOOT. It then runs sequentially, and can be redirected by
//   branches/jumps or by exceptions. A redirect that arrives during a stall
//   is held in a one-entry pending buffer. The unit can also be parked in
//   HALT until a resume or an exception arrives.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_stall          hazard stall, holds pc
//   i_redirect       taken branch/jump this cycle
//   i_redirect_tgt   redirect target (low ALIGN_BITS are forced to zero)
//   i_exc_req        exception/trap request
//   i_halt_req       request entry into HALT
//   i_resume         leave HALT
//   o_pc             current fetch address (registered)
//   o_pc_seq         o_pc + INCR, modulo 2^WIDTH
//   o_fetch_valid    o_pc is a valid fetch this cycle
//   o_halted         unit is in HALT
//   o_pend_valid     a redirect is buffered behind a stall
//   o_misalign_err   one-cycle pulse after an accepted misaligned redirect

module pc_ctrl_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int                 INCR         = 4,
    parameter int                 ALIGN_BITS   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_tgt,
    input  logic             i_exc_req,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_seq,
    output logic             o_fetch_valid,
    output logic             o_halted,
    output logic             o_pend_valid,
    output logic             o_misalign_err
);

    // Mask of the target bits that must be zero; evaluates to all zeros when ALIGN_BITS is 0.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             r_pend_valid;
    logic             w_pend_valid_nxt;
    logic [WIDTH-1:0] r_pend_tgt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;
    logic             r_misalign;
    logic             w_misalign_nxt;

    logic [WIDTH-1:0] w_pc_seq;
    logic [WIDTH-1:0] w_tgt_aligned;
    logic             w_tgt_misaligned;

    assign w_pc_seq         = r_pc + WIDTH'(INCR);
    assign w_tgt_aligned    = i_redirect_tgt & ~ALIGN_MASK;
    assign w_tgt_misaligned = |(i_redirect_tgt & ALIGN_MASK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pend_valid <= 1'b0;
            r_pend_tgt   <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_tgt   <= w_pend_tgt_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_tgt_nxt   = r_pend_tgt;
        w_misalign_nxt   = 1'b0;

        unique case (r_state)
            // Bubble cycle: every request is dropped.
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (i_exc_req) begin
                    w_pc_nxt         = EXC_VECTOR;
                    w_pend_valid_nxt = 1'b0;
                end else if (i_redirect) begin
                    w_misalign_nxt = w_tgt_misaligned;
                    if (!i_stall) begin
                        // A fresh redirect supersedes anything still buffered.
                        w_pc_nxt         = w_tgt_aligned;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_pend_tgt_nxt   = w_tgt_aligned;
                        w_pend_valid_nxt = 1'b1;
                    end
                end else if (r_pend_valid && !i_stall) begin
                    w_pc_nxt         = r_pend_tgt;
                    w_pend_valid_nxt = 1'b0;
                end else if (i_stall) begin
                    w_pc_nxt = r_pc;
                end else if (i_halt_req) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pc_nxt = w_pc_seq;
                end
            end

            ST_HALT: begin
                if (i_exc_req) begin
                    w_state_nxt      = ST_RUN;
                    w_pc_nxt         = EXC_VECTOR;
                    w_pend_valid_nxt = 1'b0;
                end else if (i_resume) begin
                    // pc is unchanged, so the halted address is fetched again.
                    w_state_nxt = ST_RUN;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign o_pc           = r_pc;
    assign o_pc_seq       = w_pc_seq;
    assign o_fetch_valid  = (r_state == ST_RUN);
    assign o_halted       = (r_state == ST_HALT);
    assign o_pend_valid   = r_pend_valid;
    assign o_misalign_err = r_misalign;

endmodule
